// File: rtl/byte_assembler_pkg.sv
// byte_assembler_pkg
// Shared definitions for the serial byte assembler:
//   - default payload width and inter-bit timeout
//   - FSM state encoding used by byte_assembler
package byte_assembler_pkg;

    localparam int DEFAULT_DATA_W  = 8;
    localparam int DEFAULT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/byte_assembler_if.sv
// byte_assembler_if
// Bundles the serial input side and the downstream-register output side of
// the byte assembler.
//   frame_start : one-cycle pulse opening (or restarting) a frame
//   sdi         : serial data bit, meaningful only with sdi_valid
//   sdi_valid   : qualifies sdi
//   data        : last good assembled byte (downstream register data input)
//   en          : one-cycle load strobe for the downstream register
//   err         : one-cycle pulse on parity error or timeout
//   busy        : high while a frame is in progress
// Modports: master drives the serial side, slave is the assembler.
interface byte_assembler_if
    import byte_assembler_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic              frame_start;
    logic              sdi;
    logic              sdi_valid;
    logic [DATA_W-1:0] data;
    logic              en;
    logic              err;
    logic              busy;

    modport master (
        output frame_start, sdi, sdi_valid,
        input  data, en, err, busy
    );

    modport slave (
        input  frame_start, sdi, sdi_valid,
        output data, en, err, busy
    );
endinterface

// File: rtl/byte_assembler_gap_timer.sv
// gap_timer
// Counts consecutive idle cycles inside a frame.
//   clk, rst : clock and synchronous active-high reset
//   clear    : restart the count from zero
//   tick     : one idle cycle elapsed
//   expired  : combinational, high on the tick that brings the count to TIMEOUT
// The count wraps to zero on expiry so the next frame starts clean.
module gap_timer
    import byte_assembler_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // Expiry is flagged on the edge that would make the count equal TIMEOUT,
    // letting the FSM react on that same edge.
    assign expired = tick && (r_count == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst || clear || expired) begin
            r_count <= '0;
        end else if (tick) begin
            r_count <= r_count + 1'b1;
        end
    end
endmodule

// File: rtl/byte_assembler.sv
// byte_assembler
// Assembles DATA_W serial bits (MSB first) followed by an even-parity bit
// into a byte for a downstream register.
//   clk, rst : clock and synchronous active-high reset
//   bus      : byte_assembler_if slave (frame_start/sdi/sdi_valid in,
//              data/en/err/busy out)
// A good frame updates data and pulses en in the DONE cycle; a bad parity or
// an inter-bit gap of TIMEOUT cycles pulses err and discards the frame.
module byte_assembler
    import byte_assembler_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    byte_assembler_if.slave   bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_en;
    logic              r_err;

    logic w_in_frame;
    logic w_tick;
    logic w_clear;
    logic w_expired;
    logic w_parity_ok;

    // frame_start wins over sdi_valid, so a restart cycle is neither a bit
    // nor an idle cycle for the gap timer.
    assign w_in_frame  = (r_state == ST_SHIFT) || (r_state == ST_PARITY);
    assign w_tick      = w_in_frame && !bus.frame_start && !bus.sdi_valid;
    assign w_clear     = !w_in_frame || bus.frame_start || bus.sdi_valid;
    assign w_parity_ok = ~^{r_shift, bus.sdi};

    gap_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_clear),
        .tick    (w_tick),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_data    <= '0;
            r_bit_cnt <= '0;
            r_en      <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_en  <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.frame_start) begin
                        r_state   <= ST_SHIFT;
                        r_shift   <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (bus.frame_start) begin
                        r_shift   <= '0;
                        r_bit_cnt <= '0;
                    end else if (bus.sdi_valid) begin
                        r_shift   <= {r_shift[DATA_W-2:0], bus.sdi};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state <= ST_PARITY;
                        end
                    end else if (w_expired) begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_PARITY: begin
                    if (bus.frame_start) begin
                        r_state   <= ST_SHIFT;
                        r_shift   <= '0;
                        r_bit_cnt <= '0;
                    end else if (bus.sdi_valid) begin
                        // Result is registered so en/err/data appear in DONE.
                        r_state <= ST_DONE;
                        if (w_parity_ok) begin
                            r_en   <= 1'b1;
                            r_data <= r_shift;
                        end else begin
                            r_err  <= 1'b1;
                        end
                    end else if (w_expired) begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (bus.frame_start) begin
                        r_state   <= ST_SHIFT;
                        r_shift   <= '0;
                        r_bit_cnt <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.data = r_data;
    assign bus.en   = r_en;
    assign bus.err  = r_err;
    assign bus.busy = (r_state != ST_IDLE);
endmodule

// File: doc/byte_assembler.md
BYTE_ASSEMBLER -- requirements
Module: byte_assembler

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the payload width in bits.
REQ-002 Parameter TIMEOUT, default 16, SHALL set the maximum consecutive cycles without sdi_valid inside a frame.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 frame_start  input  1  SHALL be a one-cycle pulse that opens a frame.
REQ-006 sdi  input  1  SHALL be the serial data bit, sampled only when sdi_valid=1.
REQ-007 sdi_valid  input  1  SHALL qualify sdi.
REQ-008 data  output  DATA_W  SHALL be the last good assembled byte and feed the downstream register data input.
REQ-009 en  output  1  SHALL be a one-cycle load strobe for the downstream register.
REQ-010 err  output  1  SHALL be a one-cycle pulse on a parity error or timeout.
REQ-011 busy  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT, PARITY and DONE.
REQ-013 IDLE: frame_start=1 -> SHIFT, with bit counter, shift register and gap timer cleared; sdi_valid SHALL be ignored in IDLE, including the cycle in which frame_start is high.
REQ-014 SHIFT: each sdi_valid=1 cycle SHALL shift sdi in MSB-first (shift left, sdi into bit 0) and increment the bit counter.
REQ-015 SHIFT -> PARITY SHALL occur on the edge that accepts bit DATA_W.
REQ-016 PARITY: the next sdi_valid=1 bit SHALL be taken as an even-parity bit (XOR of payload and parity = 0 means good), with transition to DONE.
REQ-017 DONE, good parity: data SHALL take the assembled byte and en SHALL be 1 for exactly this one cycle, then IDLE.
REQ-018 DONE, bad parity: err SHALL be 1 for one cycle, data SHALL be unchanged, en SHALL stay 0, then IDLE.
REQ-019 Latency: en SHALL assert in the cycle immediately after the edge that samples the parity bit.
REQ-020 Gap timer: it SHALL increment on each SHIFT/PARITY cycle with sdi_valid=0 and clear on sdi_valid=1.
REQ-021 Timeout: on reaching TIMEOUT, the block SHALL pulse err for one cycle and enter IDLE, discarding the partial frame.
REQ-022 frame_start=1 in SHIFT or PARITY SHALL restart the frame (counters cleared, stay/enter SHIFT) with no err; in that cycle frame_start SHALL take priority over sdi_valid.
REQ-023 frame_start=1 in DONE SHALL be honoured: output the DONE result, then go to SHIFT instead of IDLE.
REQ-024 en and err SHALL never be high in the same cycle.
REQ-025 data SHALL change only in a DONE cycle with good parity.

Reset
REQ-026 rst=1 SHALL force state IDLE, data=0, en=0, err=0, busy=0, bit counter=0 and gap timer=0 on the next edge.
REQ-027 rst mid-frame SHALL abandon the frame with no en and no err pulse.
REQ-028 rst SHALL take priority over all other inputs.

Structure
REQ-029 State encodings and the DATA_W/TIMEOUT defaults SHALL live in shared package byte_assembler_pkg.
REQ-030 The gap timer SHALL be a sub-module gap_timer (inputs clk, rst, clear, tick; output expired).
REQ-031 en and data SHALL connect directly to the downstream register's en and data ports with no added pipeline stage.

Verification
REQ-032 frame_start, then bits of 0xFD MSB-first, then parity 1 -> en=1 for one cycle, data=0xFD, err=0.
REQ-033 Back-to-back frames 0x01 (parity 1) and 0xEE (parity 0) with frame_start in the DONE cycle of the first -> two en pulses, data=0x01 then 0xEE.
REQ-034 0x82 with parity 1 -> err=1 for one cycle, en=0, data keeps its previous value.
REQ-035 frame_start, 3 bits, then 16 idle cycles -> err pulse on timeout, busy=0 afterwards, data unchanged.
REQ-036 frame_start re-pulsed after 5 bits, then full 0x77 with parity 0 -> no err, single en, data=0x77.
REQ-037 rst=1 asserted after 4 bits of 0xD4 -> outputs all 0 next cycle and no en/err pulse; a following frame 0xD4 with parity 0 -> data=0xD4.
